seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
- Sequential shift-and-add multiplier controller; one WIDTH x WIDTH unsigned multiply per start, one partial product per clock.
- Owns the operand/accumulator registers, iteration counter and start/busy/done handshake.
- Reports the full 2*WIDTH product plus Z (zero) and V (overflow) flags, with the same flag meanings as the combinational multiplier block.
- Sits between the lab top-level/ALU select logic and the result/flag display registers.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  WIDTH  multiplicand, captured on accepted start.
- b  input  WIDTH  multiplier, captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse: out/V/Z updated with a new result.
- out  output  2*WIDTH  unsigned product a*b, held until the next done.
- V  output  1  overflow: product upper WIDTH bits nonzero (result does not fit WIDTH bits).
- Z  output  1  zero: product == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, out=0, V=0, Z=0. Internal mcand, mplier, acc and count are all 0.
- FSM states: IDLE, RUN. done is a registered pulse, not a state.
- IDLE:
  - If start=1 at a rising edge: mcand <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, count <= 0, state <= RUN, busy <= 1.
  - If start=0: nothing changes; outputs hold.
- RUN, each rising edge:
  - If mplier[0]=1: acc <= acc + mcand, computed modulo 2^(2*WIDTH). It cannot wrap for legal operands.
  - Then mcand <= mcand << 1, mplier <= mplier >> 1, count <= count + 1.
- Final iteration (count == WIDTH-1 at the edge):
  - out <= final acc (including this iteration's add); Z <= (final acc == 0); V <= (final acc[2*WIDTH-1:WIDTH] != 0).
  - done <= 1, busy <= 0, state <= IDLE.
- Iteration count is fixed at exactly WIDTH; there is no early termination when mplier becomes 0, so latency is deterministic.
- Latency: start accepted at edge k, done high in the cycle following edge k+WIDTH.
  - For WIDTH=8: 8 cycles start-accept to done; throughput one result per WIDTH+? cycles, see back-to-back below.
- done is high for exactly one cycle and cleared at the next edge unless a new result is written that edge (impossible for WIDTH>=2).
- start while busy=1: ignored. The operands a/b are not captured, the in-flight operation is unaffected, and no extra done is produced.
- Back-to-back operation: during the done cycle state is already IDLE, so a start in that cycle is accepted. Sustained throughput is one result per WIDTH+1 cycles.
- out/V/Z change only on the done edge or on reset. a/b may change freely after start is accepted.
- Reset mid-operation: immediate abort to reset values. No done is produced; the partial result is discarded.
- count width: $clog2(WIDTH) bits minimum.

Test Plan:
- Basic product, WIDTH=8: reset, then a=13, b=11, start pulse.
  - Required: busy=1 for 8 cycles, then done pulse with out=16'h008F, V=0, Z=0. busy=0 in the done cycle.
- Overflow and maximum product: a=255, b=255.
  - Required: out=16'hFE01, V=1, Z=0. A second run with a=16, b=16 gives out=16'h0100, V=1, Z=0.
- Zero operand: a=0, b=200.
  - Required: out=0, Z=1, V=0, done still after exactly 8 cycles. Then a=200, b=0 gives the same response.
- start while busy: start a=3, b=5; assert start with a=7, b=7 on cycles 2-4 of RUN.
  - Required: exactly one done, out=15, busy timing unchanged, no second operation.
- Back-to-back: hold start=1 with a=2, b=3, then a=4, b=5 presented in the first done cycle.
  - Required: done pulses 9 cycles apart; out=6 then out=20.
- Reset mid-operation: start a=9, b=9; drop rst_n asynchronously (mid-cycle) at RUN cycle 4.
  - Required: busy/done/out/V/Z=0 immediately, no done afterwards. A start after release gives out=81 normally.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// fixed WIDTH-cycle latency, start/busy/done handshake and Z/V result flags.
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               V,
  output logic               Z,
  output logic               dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Handshake: start is accepted only while busy=0 (state IDLE); done is a
  // one-cycle pulse marking the cycle in which out/V/Z carry a new result.
  state_t          state, state_nxt;
  logic [PW-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [PW-1:0]   acc, acc_nxt, acc_sum;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   out_nxt;
  logic            v_nxt, z_nxt, done_nxt;

  assign busy      = (state == RUN);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      out    <= '0;
      V      <= 1'b0;
      Z      <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      count  <= count_nxt;
      out    <= out_nxt;
      V      <= v_nxt;
      Z      <= z_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    count_nxt  = count;
    out_nxt    = out;
    v_nxt      = V;
    z_nxt      = Z;
    done_nxt   = 1'b0;
    acc_sum    = mplier[0] ? (acc + mcand) : acc;

    case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt  = {{WIDTH{1'b0}}, a};
          mplier_nxt = b;
          acc_nxt    = '0;
          count_nxt  = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        acc_nxt    = acc_sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CW'(1);
        // No early exit on mplier==0 so latency stays exactly WIDTH cycles.
        if (count == LAST) begin
          out_nxt   = acc_sum;
          z_nxt     = (acc_sum == '0);
          v_nxt     = |acc_sum[PW-1:WIDTH];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: reference products queued at start,
// compared whenever the DUT pulses done.
module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, V, Z, dbg_state;
  logic [2*W-1:0] out;

  logic [2*W+1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .V(V), .Z(Z), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = x * y;
    return {p, (p[2*W-1:W] != '0), (p == '0)};
  endfunction

  // Scoreboard: every done pops one expected {out,V,Z}.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [2*W+1:0] e;
        e = exp_q.pop_front();
        check_val("out", 32'(out), 32'(e[2*W+1:2]));
        check_val("V", 32'(V), 32'(e[1]));
        check_val("Z", 32'(Z), 32'(e[0]));
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    if (!busy) exp_q.push_back(model(x, y));
  endtask

  // One operation with busy/done timing checks; poke asserts start in RUN cycles 2-4.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    int d0;
    @(negedge clk);
    d0 = done_cnt;
    drive_start(x, y);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check_val($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
      check_val($sformatf("done_c%0d", i), 32'(done), 32'd0);
      if (poke && i >= 2 && i <= 4) begin
        start = 1'b1; a = 7; b = 7;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_val("done_cleared", 32'(done), 32'd0);
    check_val("one_done", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
    if (!done) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t;
    logic [W-1:0] rx, ry;
    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_out", 32'(out), 32'd0);
    check_val("rst_vz", {30'd0, V, Z}, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd16, 8'd16, 1'b0);
    run_op(8'd0, 8'd200, 1'b0);
    run_op(8'd200, 8'd0, 1'b0);
    run_op(8'd3, 8'd5, 1'b1);

    // Back-to-back: start held, second operands presented in the done cycle.
    @(negedge clk);
    drive_start(8'd2, 8'd3);
    wait_done(t);
    check_val("b2b_first_lat", 32'(t), W + 1);
    a = 8'd4;
    b = 8'd5;
    exp_q.push_back(model(8'd4, 8'd5));
    @(negedge clk);
    start = 1'b0;
    check_val("b2b_accepted", 32'(busy), 32'd1);
    wait_done(t);
    check_val("b2b_spacing", 32'(t + 1), W + 1);
    @(negedge clk);

    // Reset mid-operation.
    drive_start(8'd9, 8'd9);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_out", 32'(out), 32'd0);
    check_val("abort_vz", {30'd0, V, Z}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t = done_cnt;
    repeat (12) @(negedge clk);
    check_val("no_done_after_abort", 32'(done_cnt - t), 32'd0);
    run_op(8'd9, 8'd9, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      run_op(rx, ry, 1'b0);
    end

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
